instr_fetch: RTL

- Fetch stage directly upstream of the microcode decoder (ucode).
- Reads instruction bytes from program memory over a req/ack handshake and assembles the opcode plus optional operand byte, w.
- Presents opcode/w to the decoder with a valid/ready handshake.
- Accepts PC redirects from the jump/stack logic.

---
 rtl/instr_fetch.sv | 89 ++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetches opcode and optional operand byte over req/ack and hands them to the decoder.
module instr_fetch #(
  parameter int                    ADDR_WIDTH   = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    LONG_OP_BIT  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_data,
  input  logic                  mem_ack,
  output logic [7:0]            opcode,
  output logic [7:0]            w,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr
);
  typedef enum logic [1:0] {FETCH_OP, FETCH_W, HOLD} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] pc;
  logic req_nx, valid_nx;
  logic ack, long_op;
  assign ack = mem_req & mem_ack;
  assign long_op = mem_data[LONG_OP_BIT];
  assign mem_addr = pc;
  always_comb begin
    state_nx = state;
    req_nx = mem_req;
    valid_nx = instr_valid;
    if (redirect_valid) begin
      state_nx = FETCH_OP;
      req_nx = 1'b0;
      valid_nx = 1'b0;
    end else begin
      case (state)
        FETCH_OP: begin
          req_nx = ack ? 1'b0 : (mem_req | fetch_en);
          state_nx = ack ? (long_op ? FETCH_W : HOLD) : FETCH_OP;
          valid_nx = ack & ~long_op;
        end
        FETCH_W: begin
          req_nx = ~ack;
          state_nx = ack ? HOLD : FETCH_W;
          valid_nx = ack;
        end
        default: begin
          state_nx = instr_ready ? FETCH_OP : HOLD;
          valid_nx = ~instr_ready;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH_OP;
      pc <= RESET_VECTOR;
      mem_req <= 1'b0;
      instr_valid <= 1'b0;
      opcode <= 8'h00;
      w <= 8'h00;
      instr_pc <= RESET_VECTOR;
      next_pc <= RESET_VECTOR;
    end else begin
      state <= state_nx;
      mem_req <= req_nx;
      instr_valid <= valid_nx;
      if (redirect_valid) pc <= redirect_addr;
      else if (ack) begin
        pc <= pc + 1'b1;
        if (state == FETCH_OP) begin
          opcode <= mem_data;
          instr_pc <= pc;
          if (!long_op) begin
            w <= 8'h00;
            next_pc <= pc + 1'b1;
          end
        end else begin
          w <= mem_data;
          next_pc <= pc + 1'b1;
        end
      end
    end
  end
endmodule
